// File: rtl/deadlock_scan_sequencer_if.sv
// Report channel of the deadlock scan sequencer.
// Valid/ready handshake carrying the deadlocked monitor index and info.
interface deadlock_scan_sequencer_if #(
   parameter int INFO_W = 4
);
   logic              rpt_valid;
   logic              rpt_ready;
   logic [3:0]        rpt_idx;
   logic [INFO_W-1:0] rpt_info;

   modport master (
      output rpt_valid,
      output rpt_idx,
      output rpt_info,
      input  rpt_ready
   );

   modport slave (
      input  rpt_valid,
      input  rpt_idx,
      input  rpt_info,
      output rpt_ready
   );
endinterface

// File: rtl/deadlock_scan_sequencer.sv
// Round-robin scan of deadlock monitors; a monitor blocked for THRESH
// consecutive samples is reported once, then the sequencer halts.
module deadlock_scan_sequencer #(
   parameter int NUM_MON = 4,
   parameter int INFO_W  = 4,
   parameter int THRESH  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      clear,
   input  logic [NUM_MON-1:0]        mon_block,
   input  logic [NUM_MON*INFO_W-1:0] mon_info,
   output logic                      deadlock,
   output logic [3:0]                scan_idx,
   deadlock_scan_sequencer_if.master rpt
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      CONFIRM,
      REPORT,
      HALT
   } state_t;

   localparam logic [3:0] LAST    = 4'(NUM_MON - 1);
   localparam logic [7:0] CNT_TOP = 8'(THRESH - 1);

   state_t            state;
   logic [3:0]        cap_idx;
   logic [7:0]        cnt;

   logic              blk_scan;
   logic              blk_cap;
   logic [INFO_W-1:0] cap_info;
   logic [3:0]        nxt_scan;
   logic [3:0]        nxt_cap;

   // Only the bit under examination is ever looked at.
   always_comb begin
      blk_scan = 1'b0;
      blk_cap  = 1'b0;
      cap_info = '0;
      for (int i = 0; i < NUM_MON; i++) begin
         if (scan_idx == 4'(i)) blk_scan = mon_block[i];
         if (cap_idx == 4'(i)) begin
            blk_cap  = mon_block[i];
            cap_info = mon_info[i*INFO_W +: INFO_W];
         end
      end
   end

   assign nxt_scan = (scan_idx == LAST) ? 4'd0 : scan_idx + 4'd1;
   assign nxt_cap  = (cap_idx == LAST) ? 4'd0 : cap_idx + 4'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         scan_idx      <= '0;
         cap_idx       <= '0;
         cnt           <= '0;
         deadlock      <= 1'b0;
         rpt.rpt_valid <= 1'b0;
         rpt.rpt_idx   <= '0;
         rpt.rpt_info  <= '0;
      end else if (clear) begin
         state         <= IDLE;
         scan_idx      <= '0;
         cnt           <= '0;
         deadlock      <= 1'b0;
         rpt.rpt_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) begin
                  state    <= SCAN;
                  scan_idx <= '0;
               end
            end
            SCAN: begin
               if (!enable) begin
                  state    <= IDLE;
                  scan_idx <= '0;
                  cnt      <= '0;
               end else if (blk_scan) begin
                  state   <= CONFIRM;
                  cap_idx <= scan_idx;
                  cnt     <= 8'd1;
               end else begin
                  scan_idx <= nxt_scan;
               end
            end
            CONFIRM: begin
               if (!enable) begin
                  state    <= IDLE;
                  scan_idx <= '0;
                  cnt      <= '0;
               end else if (!blk_cap) begin
                  state    <= SCAN;
                  scan_idx <= nxt_cap;
                  cnt      <= '0;
               end else if (cnt == CNT_TOP) begin
                  state         <= REPORT;
                  cnt           <= '0;
                  deadlock      <= 1'b1;
                  rpt.rpt_valid <= 1'b1;
                  rpt.rpt_idx   <= cap_idx;
                  rpt.rpt_info  <= cap_info;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            REPORT: begin
               if (rpt.rpt_ready) begin
                  state         <= HALT;
                  rpt.rpt_valid <= 1'b0;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_deadlock_scan_sequencer.sv
// Directed bench for deadlock_scan_sequencer (4 monitors, THRESH 16).
// Linear stimulus with immediate assertions at each check point.
module tb_deadlock_scan_sequencer;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        clear;
   logic [3:0]  mon_block;
   logic [15:0] mon_info;
   logic        deadlock;
   logic [3:0]  scan_idx;

   int n_chk  = 0;
   int n_fail = 0;

   deadlock_scan_sequencer_if #(.INFO_W(4)) rif ();

   deadlock_scan_sequencer #(
      .NUM_MON (4),
      .INFO_W  (4),
      .THRESH  (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .mon_block (mon_block),
      .mon_info  (mon_info),
      .deadlock  (deadlock),
      .scan_idx  (scan_idx),
      .rpt       (rif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset         = 1'b0;
      enable        = 1'b0;
      clear         = 1'b0;
      mon_block     = 4'b0000;
      mon_info      = 16'hDB57;
      rif.rpt_ready = 1'b0;
      #2;
      chk("rst_valid", 32'(rif.rpt_valid), 0);
      chk("rst_idx", 32'(rif.rpt_idx), 0);
      chk("rst_info", 32'(rif.rpt_info), 0);
      chk("rst_dl", 32'(deadlock), 0);
      chk("rst_scan", 32'(scan_idx), 0);
      tick(2);
      reset = 1'b1;

      // Monitor 2 held blocked: scan 0,1,2 then 16 samples to report
      mon_block = 4'b0100;
      enable    = 1'b1;
      tick(1);
      chk("s1_scan0", 32'(scan_idx), 0);
      tick(1);
      chk("s1_scan1", 32'(scan_idx), 1);
      tick(1);
      chk("s1_scan2", 32'(scan_idx), 2);
      tick(15);
      chk("s1_novalid15", 32'(rif.rpt_valid), 0);
      chk("s1_nodl15", 32'(deadlock), 0);
      chk("s1_hold2", 32'(scan_idx), 2);
      tick(1);
      chk("s1_valid", 32'(rif.rpt_valid), 1);
      chk("s1_idx", 32'(rif.rpt_idx), 2);
      chk("s1_info", 32'(rif.rpt_info), 32'hB);
      chk("s1_dl", 32'(deadlock), 1);

      // Backpressure: five more cycles with ready low, fields stable
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("bp_valid", 32'(rif.rpt_valid), 1);
         chk("bp_idx", 32'(rif.rpt_idx), 2);
         chk("bp_info", 32'(rif.rpt_info), 32'hB);
      end
      rif.rpt_ready = 1'b1;
      tick(1);
      chk("hs_valid", 32'(rif.rpt_valid), 0);
      chk("hs_dl", 32'(deadlock), 1);
      rif.rpt_ready = 1'b0;
      enable        = 1'b0;
      mon_block     = 4'b0000;
      tick(3);
      chk("halt_dl", 32'(deadlock), 1);
      chk("halt_valid", 32'(rif.rpt_valid), 0);
      chk("halt_idx", 32'(rif.rpt_idx), 2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("clr_dl", 32'(deadlock), 0);
      chk("clr_idx", 32'(rif.rpt_idx), 2);
      chk("clr_info", 32'(rif.rpt_info), 32'hB);
      chk("clr_scan", 32'(scan_idx), 0);

      // Monitor 1 blocked for 10 samples only
      mon_block = 4'b0010;
      enable    = 1'b1;
      tick(3);
      chk("s2_cap1", 32'(scan_idx), 1);
      tick(9);
      chk("s2_novalid", 32'(rif.rpt_valid), 0);
      mon_block = 4'b0000;
      tick(1);
      chk("s2_resume2", 32'(scan_idx), 2);
      chk("s2_nodl", 32'(deadlock), 0);
      tick(1);
      chk("s2_scan3", 32'(scan_idx), 3);

      // Wrap 3 -> 0, then a failed confirm at 3 restarts at 0
      tick(1);
      chk("wrap0", 32'(scan_idx), 0);
      tick(3);
      chk("at3", 32'(scan_idx), 3);
      mon_block = 4'b1000;
      tick(3);
      chk("conf3", 32'(scan_idx), 3);
      mon_block = 4'b0000;
      tick(1);
      chk("fail3_0", 32'(scan_idx), 0);
      chk("fail3_valid", 32'(rif.rpt_valid), 0);

      // Reset during CONFIRM at cnt 9
      mon_block = 4'b0001;
      tick(9);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_dl", 32'(deadlock), 0);
      chk("ar_valid", 32'(rif.rpt_valid), 0);
      chk("ar_idx", 32'(rif.rpt_idx), 0);
      chk("ar_info", 32'(rif.rpt_info), 0);
      chk("ar_scan", 32'(scan_idx), 0);
      reset = 1'b1;
      tick(1);
      tick(15);
      chk("ar_novalid", 32'(rif.rpt_valid), 0);
      tick(1);
      chk("ar_valid2", 32'(rif.rpt_valid), 1);
      chk("ar_idx2", 32'(rif.rpt_idx), 0);
      chk("ar_info2", 32'(rif.rpt_info), 7);

      // Clear together with a handshake
      rif.rpt_ready = 1'b1;
      clear         = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("ch_valid", 32'(rif.rpt_valid), 0);
      chk("ch_dl", 32'(deadlock), 0);

      // Ready already high on entry: single-cycle valid pulse
      tick(1);
      tick(15);
      chk("p_novalid", 32'(rif.rpt_valid), 0);
      tick(1);
      chk("p_valid", 32'(rif.rpt_valid), 1);
      tick(1);
      chk("p_drop", 32'(rif.rpt_valid), 0);
      chk("p_dl", 32'(deadlock), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
